ladybird_bus_arbiter_rr: RTL and testbench
==========================================

# ladybird_bus_arbiter_rr

Synthesizable round-robin arbiter that shares one ladybird bus target (e.g. IRAM) between `N_INPUT` requesters, such as the instruction-RAM writer and the core instruction port. It multiplexes request fields onto the target, holds a selection stable until the target grants it, and routes each in-order response back to its originator through an ID FIFO. It replaces the behavioural arbitrator in synthesized top levels.

## Interface
- `N_INPUT`, default 2: number of requesters, ≥2.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width, a multiple of 8.
- `MAX_OUTSTANDING`, default 2: number of accepted requests awaiting response, ≥1.
- `clk`  in  1  the single clock; all state is updated on the rising edge.
- `anrst`  in  1  reset, asynchronous and active-low.
- `in_req`  in  N_INPUT  request per requester.
- `in_addr`  in  N_INPUT*ADDR_W  requester i at `[i*ADDR_W +: ADDR_W]`.
- `in_wstrb`  in  N_INPUT*DATA_W/8  write strobes; all-zero means read.
- `in_wdata`  in  N_INPUT*DATA_W  write data.
- `in_gnt`  out  N_INPUT  request accepted this cycle; one-hot or zero.
- `in_rvalid`  out  N_INPUT  response valid for requester i; one-hot or zero.
- `in_rdata`  out  DATA_W  response data, broadcast to all requesters.
- `out_req`, `out_addr`, `out_wstrb`, `out_wdata`  out  1/ADDR_W/DATA_W/8/DATA_W  muxed request to the target.
- `out_gnt`  in  1  target accepts the request.
- `out_rvalid`, `out_rdata`  in  1/DATA_W  target response; exactly one response per accepted request (writes included), returned in order.
- `err_orphan`  out  1  sticky: `out_rvalid` was seen while no request was outstanding.

## Operation
- State: priority pointer `ptr` (the index that wins first), lock flag plus `lock_idx`, ID FIFO of depth `MAX_OUTSTANDING` (holding `$clog2(N_INPUT)`-bit IDs), occupancy count, and `err_orphan`.
- Selection when unlocked:
  - `sel` is the first index with `in_req` set, scanning `ptr, ptr+1, … mod N_INPUT`.
  - When locked, `sel = lock_idx`.
- Request path:
  - `out_req = in_req[sel] & !full`.
  - `out_addr`, `out_wstrb`, `out_wdata` carry requester `sel`'s fields.
  - `in_gnt[sel] = out_req & out_gnt`.
- Handshake when `out_req & out_gnt`:
  - push `sel` into the FIFO;
  - set `ptr = (sel+1) mod N_INPUT`;
  - clear the lock.
- Lock behaviour:
  - If `out_req & !out_gnt`, set the lock with `lock_idx = sel`, so the target sees stable fields until it grants.
  - If a locked requester drops `in_req` (protocol violation), clear the lock next cycle; nothing is pushed.
- Response path:
  - `in_rvalid[fifo_head] = out_rvalid & !empty`; `in_rdata = out_rdata`.
  - Pop the FIFO on `out_rvalid & !empty`.
- Full FIFO (count == `MAX_OUTSTANDING`): `out_req = 0` and no grant, even when a pop happens in the same cycle. The lock, if set, is kept.
- Simultaneous push and pop: count unchanged and FIFO order preserved.
- `out_rvalid` with an empty FIFO: the response is dropped, no `in_rvalid` is raised, and `err_orphan` is set until reset.
- Pointer and FIFO indices wrap modulo their size; no other arithmetic.

## Timing
- Request path is combinational: 0-cycle latency from `in_req` to `out_req`, and from `out_gnt` to `in_gnt`.
- Response path is combinational: 0-cycle latency from `out_rvalid` to `in_rvalid`.
- Pointer, lock, FIFO and error state update on the `clk` rising edge after the event.
- Reset (`anrst` low), effective immediately:
  - `ptr = 0`, lock clear, FIFO empty, `err_orphan = 0`.
  - `out_req`, `in_gnt` and `in_rvalid` are forced to 0 while `anrst` is low.
- Reset mid-transaction discards outstanding IDs. Responses arriving afterwards count as orphans.
- Throughput: one grant per cycle when `out_gnt` is held high and the FIFO is not full.

## Test plan
- Reset then idle: all outputs 0; `ptr = 0`. Requester 1 alone asserts `in_req`, `addr = 0x4`, `out_gnt = 1` → `out_addr = 0x4`, `in_gnt = 2'b10` in the same cycle; response `out_rdata = 0xDEADBEEF` next cycle → `in_rvalid = 2'b10`, `in_rdata = 0xDEADBEEF`.
- Both requesters held high, `out_gnt = 1` every cycle, `MAX_OUTSTANDING = 2`, target responds 1 cycle later → grants alternate 0,1,0,1; every `in_rvalid` matches the grant from the previous cycle.
- Requester 0 requests with `out_gnt = 0` for 3 cycles while requester 1 also asserts → `out_addr` stays at requester 0's value; grant goes to 0 on cycle 4, then to 1.
- No responses returned, both requesters active → exactly 2 grants, then `out_req = 0`. One `out_rvalid` → exactly one further grant.
- `out_rvalid` pulse after reset with nothing outstanding → `in_rvalid = 0`, `err_orphan = 1`, and it stays 1 until `anrst` is low.
- `anrst` asserted with 2 requests outstanding → FIFO empty and `ptr = 0` after reset. Next request is granted normally.

Source files
------------

// File: rtl/ladybird_bus_arbiter_rr.sv
// ============================================================================
// ladybird_bus_arbiter_rr
//
// Round-robin arbiter that shares one ladybird bus target (for example the
// instruction RAM) between N_INPUT requesters. The winning requester's fields
// are multiplexed onto the target port. A selection that the target has not
// yet granted is locked, so the target sees stable fields until it accepts.
// Every accepted request pushes the winner's index into an ID FIFO. The
// target answers in order, so the FIFO head names the requester that owns
// each response.
//
// Parameters
//   N_INPUT          number of requesters (>= 2)
//   ADDR_W           address width
//   DATA_W           data width, a multiple of 8
//   MAX_OUTSTANDING  accepted requests that may await a response (>= 1)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   anrst        asynchronous active-low reset
//   in_req       request, one bit per requester
//   in_addr      requester i address at [i*ADDR_W +: ADDR_W]
//   in_wstrb     requester i strobes at [i*DATA_W/8 +: DATA_W/8]; zero = read
//   in_wdata     requester i write data at [i*DATA_W +: DATA_W]
//   in_gnt       one-hot grant back to the requester accepted this cycle
//   in_rvalid    one-hot response valid to the owner of the response
//   in_rdata     response data, broadcast to all requesters
//   out_req      request to the target
//   out_addr     address of the selected requester
//   out_wstrb    strobes of the selected requester
//   out_wdata    write data of the selected requester
//   out_gnt      target accepts the current request
//   out_rvalid   target response valid (one per accepted request, in order)
//   out_rdata    target response data
//   err_orphan   sticky flag: a response arrived with nothing outstanding
// ============================================================================
module ladybird_bus_arbiter_rr #(
    parameter int N_INPUT         = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        anrst,
    input  logic [N_INPUT-1:0]          in_req,
    input  logic [N_INPUT*ADDR_W-1:0]   in_addr,
    input  logic [N_INPUT*DATA_W/8-1:0] in_wstrb,
    input  logic [N_INPUT*DATA_W-1:0]   in_wdata,
    output logic [N_INPUT-1:0]          in_gnt,
    output logic [N_INPUT-1:0]          in_rvalid,
    output logic [DATA_W-1:0]           in_rdata,
    output logic                        out_req,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [DATA_W/8-1:0]         out_wstrb,
    output logic [DATA_W-1:0]           out_wdata,
    input  logic                        out_gnt,
    input  logic                        out_rvalid,
    input  logic [DATA_W-1:0]           out_rdata,
    output logic                        err_orphan
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int ID_W    = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_INPUT - 1);
    localparam logic [FIFO_AW-1:0] LAST_SLOT = FIFO_AW'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    ptr_q,      ptr_d;
    logic               lock_q,     lock_d;
    logic [ID_W-1:0]    lock_idx_q, lock_idx_d;
    logic [ID_W-1:0]    fifo_mem_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]    fifo_mem_d [MAX_OUTSTANDING];
    logic [FIFO_AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               err_orphan_q, err_orphan_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [ID_W-1:0] sel;
    logic [ID_W:0]   cand;
    logic            found;
    logic            full;
    logic            empty;
    logic            handshake;
    logic            pop;
    logic [ID_W-1:0] fifo_head;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign fifo_head = fifo_mem_q[rd_ptr_q];

    // Selection. When locked the held index wins unconditionally. Otherwise
    // scan from ptr upward, wrapping at N_INPUT. The candidate carries one
    // extra bit so the wrap can be detected before it is folded back into
    // range. With no request pending, sel rests on ptr; out_req is then low
    // anyway.
    always_comb begin
        sel   = ptr_q;
        cand  = '0;
        found = 1'b0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int k = 0; k < N_INPUT; k++) begin
                cand = {1'b0, ptr_q} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(N_INPUT)) begin
                    cand = cand - (ID_W+1)'(N_INPUT);
                end
                if (!found && in_req[cand[ID_W-1:0]]) begin
                    sel   = cand[ID_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    // Request path. Both out_req and the response strobe are gated by anrst,
    // so nothing leaks out combinationally while reset is held.
    assign out_req   = anrst & in_req[sel] & !full;
    assign handshake = out_req & out_gnt;
    assign pop       = anrst & out_rvalid & !empty;

    always_comb begin
        out_addr  = '0;
        out_wstrb = '0;
        out_wdata = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (sel == ID_W'(i)) begin
                out_addr  = in_addr[i*ADDR_W +: ADDR_W];
                out_wstrb = in_wstrb[i*STRB_W +: STRB_W];
                out_wdata = in_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant and response-valid fan-out. Each is one-hot or zero: only the
    // selected requester is granted, and only the FIFO head gets the reply.
    always_comb begin
        in_gnt    = '0;
        in_rvalid = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            in_gnt[i]    = handshake & (sel == ID_W'(i));
            in_rvalid[i] = pop & (fifo_head == ID_W'(i));
        end
    end

    assign in_rdata   = out_rdata;
    assign err_orphan = err_orphan_q;

    // ------------------------------------------------------------------
    // Pointer and lock next-state
    // ------------------------------------------------------------------
    // A grant moves the pointer past the winner and releases the lock. An
    // offered-but-refused request locks onto the current selection. A locked
    // requester that withdraws its request (illegal, but tolerated) loses the
    // lock. A full FIFO keeps out_req low, so an existing lock is simply held.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            ptr_d  = (sel == LAST_ID) ? '0 : sel + ID_W'(1);
            lock_d = 1'b0;
        end else if (out_req) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (lock_q && !in_req[lock_idx_q]) begin
            lock_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ID FIFO next-state
    // ------------------------------------------------------------------
    // A push never coincides with full (out_req is blocked), so the write
    // slot is always free. Push and pop together leave the count unchanged.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (handshake) begin
            fifo_mem_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + FIFO_AW'(1);
        end
        if (handshake && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !handshake) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A response with nothing outstanding is dropped and flagged until reset.
    always_comb begin
        err_orphan_d = err_orphan_q | (out_rvalid & empty);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            ptr_q        <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_q[i] <= fifo_mem_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!anrst)
        $onehot0(in_gnt));
    a_rvalid_onehot : assert property (@(posedge clk) disable iff (!anrst)
        $onehot0(in_rvalid));
    a_count_range : assert property (@(posedge clk) disable iff (!anrst)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_ladybird_bus_arbiter_rr.sv
// ============================================================================
// tb_ladybird_bus_arbiter_rr
//
// Directed bench for the round-robin arbiter with two requesters and two
// outstanding slots. Requester 0 is a read at 0x100, requester 1 a full-word
// write at 0x4. A table of per-cycle records drives the main sequence, and
// hand-written steps cover reset while requests are outstanding.
// ============================================================================
module tb_ladybird_bus_arbiter_rr;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    localparam logic [AW-1:0]   ADDR0  = 32'h0000_0100;
    localparam logic [AW-1:0]   ADDR1  = 32'h0000_0004;
    localparam logic [DW/8-1:0] WSTRB0 = 4'h0;
    localparam logic [DW/8-1:0] WSTRB1 = 4'hF;
    localparam logic [DW-1:0]   WDATA0 = 32'h0000_00A0;
    localparam logic [DW-1:0]   WDATA1 = 32'h0000_00B1;

    logic                   clk;
    logic                   anrst;
    logic [N-1:0]           in_req;
    logic [N*AW-1:0]        in_addr;
    logic [N*DW/8-1:0]      in_wstrb;
    logic [N*DW-1:0]        in_wdata;
    logic [N-1:0]           in_gnt;
    logic [N-1:0]           in_rvalid;
    logic [DW-1:0]          in_rdata;
    logic                   out_req;
    logic [AW-1:0]          out_addr;
    logic [DW/8-1:0]        out_wstrb;
    logic [DW-1:0]          out_wdata;
    logic                   out_gnt;
    logic                   out_rvalid;
    logic [DW-1:0]          out_rdata;
    logic                   err_orphan;

    int compared;
    int mismatched;

    ladybird_bus_arbiter_rr #(
        .N_INPUT         (N),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk        (clk),
        .anrst      (anrst),
        .in_req     (in_req),
        .in_addr    (in_addr),
        .in_wstrb   (in_wstrb),
        .in_wdata   (in_wdata),
        .in_gnt     (in_gnt),
        .in_rvalid  (in_rvalid),
        .in_rdata   (in_rdata),
        .out_req    (out_req),
        .out_addr   (out_addr),
        .out_wstrb  (out_wstrb),
        .out_wdata  (out_wdata),
        .out_gnt    (out_gnt),
        .out_rvalid (out_rvalid),
        .out_rdata  (out_rdata),
        .err_orphan (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_sel;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rvalid;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    // Drive the per-cycle inputs, then let the combinational paths settle.
    task automatic applyStimulus(input logic [1:0] req, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata);
        in_req     = req;
        out_gnt    = gnt;
        out_rvalid = rvalid;
        out_rdata  = rdata;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Full output check for one cycle; muxed fields follow the expected winner.
    task automatic checkCycle(input string tag, input logic exp_req,
                              input logic exp_sel, input logic [1:0] exp_gnt,
                              input logic [1:0] exp_rvalid,
                              input logic [31:0] exp_rdata, input logic exp_err);
        checkOutput({tag, ".out_req"},    32'(out_req),    32'(exp_req));
        checkOutput({tag, ".out_addr"},   out_addr,   exp_sel ? ADDR1 : ADDR0);
        checkOutput({tag, ".out_wstrb"},  32'(out_wstrb),
                    exp_sel ? 32'(WSTRB1) : 32'(WSTRB0));
        checkOutput({tag, ".out_wdata"},  out_wdata,  exp_sel ? WDATA1 : WDATA0);
        checkOutput({tag, ".in_gnt"},     32'(in_gnt),     32'(exp_gnt));
        checkOutput({tag, ".in_rvalid"},  32'(in_rvalid),  32'(exp_rvalid));
        checkOutput({tag, ".in_rdata"},   in_rdata,   exp_rdata);
        checkOutput({tag, ".err_orphan"}, 32'(err_orphan), 32'(exp_err));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        //            req    gnt   rv    rdata         oreq  sel   gnt    rvalid err
        // Single requester 1, response next cycle.
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
        // Both requesting, target grants every cycle and answers one later.
        vecs[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 32'h11,       1'b1, 1'b1, 2'b10, 2'b01, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 32'h22,       1'b1, 1'b0, 2'b01, 2'b10, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b1, 32'h33,       1'b1, 1'b1, 2'b10, 2'b01, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 1'b1, 32'h44,       1'b0, 1'b0, 2'b00, 2'b10, 1'b0};
        // Target stalls three cycles: requester 0 held, then 0 and 1 granted.
        vecs[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[12] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 1'b0};
        // FIFO full: no grant, not even alongside a pop; a pop frees one slot.
        vecs[13] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[14] = '{2'b11, 1'b1, 1'b1, 32'h55,       1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
        vecs[15] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[16] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
        // Drain in order, then an orphan response.
        vecs[17] = '{2'b00, 1'b0, 1'b1, 32'h66,       1'b0, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[18] = '{2'b00, 1'b0, 1'b1, 32'h77,       1'b0, 1'b1, 2'b00, 2'b01, 1'b0};
        vecs[19] = '{2'b00, 1'b0, 1'b1, 32'h88,       1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[20] = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
        // Lock on 0 overrides the pointer (now 1); locked requester drops out.
        vecs[21] = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[22] = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[23] = '{2'b10, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[24] = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 2'b00, 1'b1};
        // Second outstanding request; pointer ends at 1.
        vecs[25] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 2'b00, 1'b1};

        in_addr  = {ADDR1, ADDR0};
        in_wstrb = {WSTRB1, WSTRB0};
        in_wdata = {WDATA1, WDATA0};
        in_req     = '0;
        out_gnt    = 1'b0;
        out_rvalid = 1'b0;
        out_rdata  = '0;
        anrst      = 1'b0;

        // Outputs held at rest while reset is asserted.
        @(posedge clk);
        #1;
        applyStimulus(2'b11, 1'b1, 1'b1, 32'h1234);
        checkCycle("reset_hold", 1'b0, 1'b0, 2'b00, 2'b00, 32'h1234, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        anrst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].req, vecs[v].gnt, vecs[v].rvalid, vecs[v].rdata);
            checkCycle($sformatf("vec%0d", v), vecs[v].exp_req, vecs[v].exp_sel,
                       vecs[v].exp_gnt, vecs[v].exp_rvalid, vecs[v].rdata,
                       vecs[v].exp_err);
            @(posedge clk);
            #1;
        end

        // Reset with two requests outstanding and the sticky error set.
        anrst = 1'b0;
        applyStimulus(2'b11, 1'b1, 1'b1, 32'hAA);
        checkCycle("mid_reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'hAA, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        anrst = 1'b1;
        @(posedge clk);
        #1;

        // Discarded IDs: a late response is an orphan.
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h99);
        checkCycle("post_orphan", 1'b0, 1'b0, 2'b00, 2'b00, 32'h99, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkCycle("orphan_set", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        // Pointer back at 0: requester 0 wins with both requesting.
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        checkCycle("post_grant", 1'b1, 1'b0, 2'b01, 2'b00, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hCAFE);
        checkCycle("post_resp", 1'b0, 1'b1, 2'b00, 2'b01, 32'hCAFE, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkCycle("orphan_sticky", 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
